// File: rtl/ni_xfer_ctrl.sv
// Send/receive sequencer between the MIPS decode stage and the network interface.
// Stalls the pipeline while a transfer is pending and abandons it after TIMEOUT cycles.
module ni_xfer_ctrl #(
  parameter int DATA_W  = 32,
  parameter int DEST_W  = 2,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              out_req,
  input  logic [DEST_W-1:0] out_dest,
  input  logic [DATA_W-1:0] out_data,
  input  logic              in_req,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              mips_ni,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] ni_data_in,
  output logic              proc_valid,
  output logic [DEST_W-1:0] dest_add,
  output logic [DATA_W-1:0] proc_data,
  output logic              proc_ready_in,
  output logic              stall,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [REG_W-1:0]   rd_q, rd_nxt;
  logic               pv_nxt, prr_nxt, wb_en_nxt, err_nxt;
  logic [DEST_W-1:0]  dest_nxt;
  logic [DATA_W-1:0]  pdata_nxt, wb_data_nxt;
  logic [REG_W-1:0]   wb_addr_nxt;
  logic               expired;

  assign expired = (cnt == CNT_LAST);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rd_nxt      = rd_q;
    pv_nxt      = proc_valid;
    prr_nxt     = proc_ready_in;
    dest_nxt    = dest_add;
    pdata_nxt   = proc_data;
    wb_en_nxt   = 1'b0;
    wb_addr_nxt = wb_addr;
    wb_data_nxt = wb_data;
    err_nxt     = timeout_err;
    case (state)
      IDLE: begin
        if (out_req) begin
          state_nxt = SEND;
          pv_nxt    = 1'b1;
          dest_nxt  = out_dest;
          pdata_nxt = out_data;
          cnt_nxt   = '0;
        end else if (in_req) begin
          state_nxt = RECV;
          prr_nxt   = 1'b1;
          rd_nxt    = in_rd;
          cnt_nxt   = '0;
        end
      end
      SEND: begin
        // a handshake on the expiry edge still completes normally
        if (mips_ni) begin
          pv_nxt    = 1'b0;
          state_nxt = DONE;
        end else if (expired) begin
          pv_nxt    = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RECV: begin
        if (data_valid) begin
          prr_nxt     = 1'b0;
          wb_en_nxt   = 1'b1;
          wb_addr_nxt = rd_q;
          wb_data_nxt = ni_data_in;
          state_nxt   = DONE;
        end else if (expired) begin
          prr_nxt   = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      rd_q          <= '0;
      proc_valid    <= 1'b0;
      dest_add      <= '0;
      proc_data     <= '0;
      proc_ready_in <= 1'b0;
      wb_en         <= 1'b0;
      wb_addr       <= '0;
      wb_data       <= '0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      rd_q          <= rd_nxt;
      proc_valid    <= pv_nxt;
      dest_add      <= dest_nxt;
      proc_data     <= pdata_nxt;
      proc_ready_in <= prr_nxt;
      wb_en         <= wb_en_nxt;
      wb_addr       <= wb_addr_nxt;
      wb_data       <= wb_data_nxt;
      timeout_err   <= err_nxt;
    end
  end

  assign stall = rst_n && (((state == IDLE) && (out_req || in_req)) ||
                           (state == SEND) || (state == RECV));

endmodule

// File: tb/tb_ni_xfer_ctrl.sv
// Bench for ni_xfer_ctrl: a per-cycle vector table, then transaction-level checks
// whose expected stall/valid/write-back counts are derived arithmetically from the handshake delay.
module tb_ni_xfer_ctrl;
  localparam int TO = 6;
  localparam bit O = 1'b0;
  localparam bit I = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        out_req = 1'b0, in_req = 1'b0, mips_ni = 1'b0, data_valid = 1'b0;
  logic [1:0]  out_dest = '0;
  logic [31:0] out_data = '0, ni_data_in = '0;
  logic [4:0]  in_rd = '0;
  logic        proc_valid, proc_ready_in, stall, wb_en, timeout_err;
  logic [1:0]  dest_add;
  logic [31:0] proc_data, wb_data;
  logic [4:0]  wb_addr;

  int errors = 0;
  int checks = 0;
  bit m_err = 1'b0;

  ni_xfer_ctrl #(.DATA_W(32), .DEST_W(2), .REG_W(5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .out_req(out_req), .out_dest(out_dest), .out_data(out_data),
    .in_req(in_req), .in_rd(in_rd),
    .mips_ni(mips_ni), .data_valid(data_valid), .ni_data_in(ni_data_in),
    .proc_valid(proc_valid), .dest_add(dest_add), .proc_data(proc_data),
    .proc_ready_in(proc_ready_in), .stall(stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, oreq, ireq;
    logic [1:0]  dest;
    logic [31:0] odata;
    logic [4:0]  rd;
    logic        mni, dv;
    logic [31:0] nid;
    logic        e_stall, e_pv;
    logic [1:0]  e_dest;
    logic [31:0] e_pd;
    logic        e_prr, e_wb;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rst, oreq, ireq, input logic [1:0] dest,
                             input logic [31:0] odata, input logic [4:0] rd,
                             input logic mni, dv, input logic [31:0] nid,
                             input logic e_stall, e_pv, input logic [1:0] e_dest,
                             input logic [31:0] e_pd, input logic e_prr, e_wb,
                             input logic [4:0] e_wa, input logic [31:0] e_wd,
                             input logic e_err);
    vec_t r;
    r.rst = rst; r.oreq = oreq; r.ireq = ireq; r.dest = dest; r.odata = odata;
    r.rd = rd; r.mni = mni; r.dv = dv; r.nid = nid;
    r.e_stall = e_stall; r.e_pv = e_pv; r.e_dest = e_dest; r.e_pd = e_pd;
    r.e_prr = e_prr; r.e_wb = e_wb; r.e_wa = e_wa; r.e_wd = e_wd; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One NI instruction: handshake input rises d cycles after entering SEND/RECV.
  task automatic xfer(input bit is_send, input logic [1:0] dest, input logic [31:0] data,
                      input logic [4:0] rd, input int d);
    int stall_n, pv_n, prr_n, hs_n, wb_n;
    bit done, stable, h;
    logic [4:0]  got_wa;
    logic [31:0] got_wd, exp_wd;
    logic        err_at_done;
    stall_n = 0; pv_n = 0; prr_n = 0; hs_n = 0; wb_n = 0;
    done = 1'b0; stable = 1'b1; got_wa = '0; got_wd = '0; exp_wd = '0; err_at_done = 1'b0;
    @(negedge clk);
    out_req = is_send; in_req = !is_send;
    out_dest = dest; out_data = data; in_rd = rd;
    mips_ni = 1'b0; data_valid = 1'b0; ni_data_in = $urandom;
    #1;
    if (stall) stall_n++;
    for (int i = 1; i <= 60 && !done; i++) begin
      @(negedge clk);
      if (proc_valid) begin
        pv_n++;
        if (dest_add !== dest || proc_data !== data) stable = 1'b0;
      end
      if (proc_ready_in) prr_n++;
      if (wb_en) begin wb_n++; got_wa = wb_addr; got_wd = wb_data; end
      if (!stall) begin
        done = 1'b1;
        err_at_done = timeout_err;
      end else begin
        stall_n++;
        ni_data_in = $urandom;
        if (is_send) begin
          mips_ni = (i - 1 >= d); data_valid = 1'($urandom);
          if (proc_valid && mips_ni) hs_n++;
        end else begin
          data_valid = (i - 1 >= d); mips_ni = 1'($urandom);
          if (proc_ready_in && data_valid) begin hs_n++; exp_wd = ni_data_in; end
        end
      end
    end
    out_req = 1'b0; in_req = 1'b0; mips_ni = 1'b0; data_valid = 1'b0;
    if (!done) begin
      errors++; checks++;
      $display("FAIL xfer_budget: stall still high after 60 cycles, expected release");
    end
    h = (d < TO);
    m_err = m_err | !h;
    chk("stall_cycles", 32'(stall_n), h ? 32'(d + 2) : 32'(TO + 1));
    chk("handshakes", 32'(hs_n), h ? 32'd1 : 32'd0);
    chk("timeout_err", 32'(err_at_done), 32'(m_err));
    if (is_send) begin
      chk("valid_cycles", 32'(pv_n), h ? 32'(d + 1) : 32'(TO));
      chk("send_stable", 32'(stable), 32'd1);
      chk("send_no_wb", 32'(wb_n), 32'd0);
    end else begin
      chk("ready_cycles", 32'(prr_n), h ? 32'(d + 1) : 32'(TO));
      chk("recv_no_valid", 32'(pv_n), 32'd0);
      chk("wb_pulses", 32'(wb_n), h ? 32'd1 : 32'd0);
      if (h) begin
        chk("wb_addr", 32'(got_wa), 32'(rd));
        chk("wb_data", got_wd, exp_wd);
      end
    end
    @(negedge clk);
    chk("post_idle_stall", 32'(stall), 32'd0);
    chk("post_idle_wb", 32'(wb_en), 32'd0);
  endtask

  initial begin
    // rst oreq ireq dest odata rd mni dv nid | stall pv dest pdata prr wb wa wd err
    tbl.push_back(v(O,I,O,2'd2,32'hDEADBEEF,5'd0,I,O,32'h0, O,O,2'd0,32'h0,O,O,5'd0,32'h0,O));
    tbl.push_back(v(I,I,O,2'd2,32'hDEADBEEF,5'd0,I,O,32'h0, I,I,2'd2,32'hDEADBEEF,O,O,5'd0,32'h0,O));
    tbl.push_back(v(I,I,O,2'd2,32'hDEADBEEF,5'd0,I,O,32'h0, I,O,2'd2,32'hDEADBEEF,O,O,5'd0,32'h0,O));
    tbl.push_back(v(I,I,O,2'd2,32'hDEADBEEF,5'd0,I,O,32'h0, O,O,2'd2,32'hDEADBEEF,O,O,5'd0,32'h0,O));
    tbl.push_back(v(I,O,I,2'd0,32'h0,5'd7,I,O,32'h0, I,O,2'd2,32'hDEADBEEF,I,O,5'd0,32'h0,O));
    tbl.push_back(v(I,O,I,2'd0,32'h0,5'd7,O,O,32'h0, I,O,2'd2,32'hDEADBEEF,I,O,5'd0,32'h0,O));
    tbl.push_back(v(I,O,I,2'd0,32'h0,5'd7,O,O,32'h0, I,O,2'd2,32'hDEADBEEF,I,O,5'd0,32'h0,O));
    tbl.push_back(v(I,O,I,2'd0,32'h0,5'd7,O,O,32'h0, I,O,2'd2,32'hDEADBEEF,I,O,5'd0,32'h0,O));
    tbl.push_back(v(I,O,I,2'd0,32'h0,5'd7,O,I,32'h12345678, I,O,2'd2,32'hDEADBEEF,O,I,5'd7,32'h12345678,O));
    tbl.push_back(v(I,O,I,2'd0,32'h0,5'd7,O,I,32'h12345678, O,O,2'd2,32'hDEADBEEF,O,O,5'd7,32'h12345678,O));
    tbl.push_back(v(I,O,O,2'd0,32'h0,5'd0,O,I,32'hAAAA5555, O,O,2'd2,32'hDEADBEEF,O,O,5'd7,32'h12345678,O));
    tbl.push_back(v(I,O,I,2'd0,32'h0,5'd3,O,O,32'h0, I,O,2'd2,32'hDEADBEEF,I,O,5'd7,32'h12345678,O));
    tbl.push_back(v(O,O,I,2'd0,32'h0,5'd3,O,O,32'h0, O,O,2'd0,32'h0,O,O,5'd0,32'h0,O));
    tbl.push_back(v(I,O,O,2'd0,32'h0,5'd0,O,I,32'h55, O,O,2'd0,32'h0,O,O,5'd0,32'h0,O));
    tbl.push_back(v(I,I,I,2'd1,32'h0BADF00D,5'd9,I,I,32'h77, I,I,2'd1,32'h0BADF00D,O,O,5'd0,32'h0,O));
    tbl.push_back(v(I,I,I,2'd1,32'h0BADF00D,5'd9,I,I,32'h77, I,O,2'd1,32'h0BADF00D,O,O,5'd0,32'h0,O));
    tbl.push_back(v(I,I,I,2'd1,32'h0BADF00D,5'd9,I,I,32'h77, O,O,2'd1,32'h0BADF00D,O,O,5'd0,32'h0,O));
    tbl.push_back(v(I,O,I,2'd0,32'h0,5'd9,O,O,32'h0, I,O,2'd1,32'h0BADF00D,I,O,5'd0,32'h0,O));
    tbl.push_back(v(I,O,I,2'd0,32'h0,5'd9,O,I,32'hCAFEF00D, I,O,2'd1,32'h0BADF00D,O,I,5'd9,32'hCAFEF00D,O));
    tbl.push_back(v(I,O,I,2'd0,32'h0,5'd9,O,I,32'hCAFEF00D, O,O,2'd1,32'h0BADF00D,O,O,5'd9,32'hCAFEF00D,O));
    tbl.push_back(v(I,O,O,2'd0,32'h0,5'd0,O,O,32'h0, O,O,2'd1,32'h0BADF00D,O,O,5'd9,32'hCAFEF00D,O));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst; out_req = tbl[i].oreq; in_req = tbl[i].ireq;
      out_dest = tbl[i].dest; out_data = tbl[i].odata; in_rd = tbl[i].rd;
      mips_ni = tbl[i].mni; data_valid = tbl[i].dv; ni_data_in = tbl[i].nid;
      #1;
      chk($sformatf("row%0d stall", i), 32'(stall), 32'(tbl[i].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d proc_valid", i), 32'(proc_valid), 32'(tbl[i].e_pv));
      chk($sformatf("row%0d dest_add", i), 32'(dest_add), 32'(tbl[i].e_dest));
      chk($sformatf("row%0d proc_data", i), proc_data, tbl[i].e_pd);
      chk($sformatf("row%0d proc_ready_in", i), 32'(proc_ready_in), 32'(tbl[i].e_prr));
      chk($sformatf("row%0d wb_en", i), 32'(wb_en), 32'(tbl[i].e_wb));
      chk($sformatf("row%0d wb_addr", i), 32'(wb_addr), 32'(tbl[i].e_wa));
      chk($sformatf("row%0d wb_data", i), wb_data, tbl[i].e_wd);
      chk($sformatf("row%0d timeout_err", i), 32'(timeout_err), 32'(tbl[i].e_err));
    end

    xfer(1'b1, 2'd2, 32'hDEADBEEF, 5'd0, 0);
    xfer(1'b1, 2'd3, 32'h13572468, 5'd0, 5);
    xfer(1'b0, 2'd0, 32'h0, 5'd7, 3);
    xfer(1'b0, 2'd0, 32'h0, 5'd21, TO - 1);

    for (int n = 0; n < 30; n++)
      xfer(1'($urandom), 2'($urandom), $urandom, 5'($urandom), $urandom_range(0, TO + 2));

    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; m_err = 1'b0;
    chk("err_cleared_by_reset", 32'(timeout_err), 32'd0);

    xfer(1'b1, 2'd1, 32'hA5A5A5A5, 5'd0, 1000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mips_ni = 1'b1;
      #1;
      chk("no_send_after_timeout", 32'(proc_valid), 32'd0);
      chk("err_sticky", 32'(timeout_err), 32'd1);
    end
    mips_ni = 1'b0;
    xfer(1'b0, 2'd0, 32'h0, 5'd4, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
